// File: rtl/clock_gen_pkg.sv
// Shared types and helpers for the multi-channel clock generator.
package clock_gen_pkg;

  typedef enum logic [0:0] {
    StLocking,
    StRun
  } state_e;

  localparam int unsigned DIV_MIN = 2;

  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < DIV_MIN) ? 32'(DIV_MIN) : d;
  endfunction

  function automatic logic [31:0] clamp_phase(input logic [31:0] phase, input logic [31:0] d);
    return (phase >= d) ? 32'd0 : phase;
  endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: programmable divisor and start phase, registered outclk/tick.
module clock_div_chan
  import clock_gen_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 42
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_phase,
  output logic             outclk,
  output logic             tick
);

  logic [DIV_W-1:0] div_q, phase_q, cnt_q, cnt_d;
  logic [DIV_W-1:0] new_div, new_phase;
  logic             active_q, outclk_q, tick_q;

  always_comb begin
    new_div   = DIV_W'(clamp_div(32'(cfg_div)));
    new_phase = DIV_W'(clamp_phase(32'(cfg_phase), 32'(new_div)));
    // First running cycle restarts from the stored phase so all channels align.
    if (!active_q) begin
      cnt_d = phase_q;
    end else if (cnt_q == div_q - 1'b1) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q    <= DIV_W'(DEFAULT_DIV);
      phase_q  <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      outclk_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      if (load) begin
        div_q   <= new_div;
        phase_q <= new_phase;
      end
      active_q <= run;
      if (run) begin
        cnt_q    <= cnt_d;
        outclk_q <= (cnt_d < (div_q >> 1));
        tick_q   <= (cnt_d == div_q - 1'b1);
      end else begin
        cnt_q    <= phase_q;
        outclk_q <= 1'b0;
        tick_q   <= 1'b0;
      end
    end
  end

  assign outclk = outclk_q;
  assign tick   = tick_q;

endmodule

// File: rtl/clock_gen_multi.sv
// Multi-channel divided clock / tick generator with lock FSM and config handshake.
module clock_gen_multi
  import clock_gen_pkg::*;
#(
  parameter int unsigned NUM_CLOCKS  = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 42,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3:0]            cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] tick,
  output logic                  locked
);

  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

  state_e              state_q;
  logic [LOCK_W-1:0]   lock_cnt_q;
  logic                locked_q, ready_q, err_q;
  logic                accept, chan_ok, hit, lock_done, run_next;
  logic [NUM_CLOCKS-1:0] load;

  always_comb begin
    accept    = cfg_valid & ready_q;
    chan_ok   = 32'(cfg_chan) < NUM_CLOCKS;
    hit       = accept & chan_ok;
    lock_done = (lock_cnt_q == LOCK_W'(LOCK_CYCLES - 1));
    // Channels need the next state so their registered outputs line up with it.
    run_next  = rst & (((state_q == StRun) & ~hit) | ((state_q == StLocking) & lock_done));
  end

  always_ff @(posedge refclk) begin
    if (!rst) begin
      state_q    <= StLocking;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StLocking: begin
          if (lock_done) begin
            state_q    <= StRun;
            lock_cnt_q <= '0;
            locked_q   <= 1'b1;
            ready_q    <= 1'b1;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (hit) begin
            state_q    <= StLocking;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            ready_q    <= 1'b0;
          end else if (accept) begin
            err_q <= 1'b1;
          end
        end
        default: state_q <= StLocking;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
    assign load[i] = rst & hit & (cfg_chan == 4'(i));

    clock_div_chan #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clk      (refclk),
      .rst      (rst),
      .load     (load[i]),
      .run      (run_next),
      .cfg_div  (cfg_div),
      .cfg_phase(cfg_phase),
      .outclk   (outclk[i]),
      .tick     (tick[i])
    );
  end

  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_clock_gen_multi.sv
// Directed bench for clock_gen_multi: lock timing, dividers, clamping, handshake, reset.
module tb_clock_gen_multi;
  localparam int N = 4;

  logic          refclk, rst, cfg_valid, cfg_ready, cfg_err, locked;
  logic [3:0]    cfg_chan;
  logic [15:0]   cfg_div, cfg_phase;
  logic [N-1:0]  outclk, tick;

  int passed = 0;
  int total  = 0;

  logic [N-1:0] so [0:127];
  logic [N-1:0] st [0:127];

  clock_gen_multi dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .cfg_err  (cfg_err),
    .outclk   (outclk),
    .tick     (tick),
    .locked   (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  // Reference pattern: counter value (p+off+k) mod d in sample k.
  function automatic logic [127:0] model(input int d, input int p, input int off, input int n,
                                         input bit want_tick);
    logic [127:0] r = '0;
    for (int k = 0; k < n; k++) begin
      int c = (p + off + k) % d;
      r[k] = want_tick ? (c == d - 1) : (c < d / 2);
    end
    return r;
  endfunction

  function automatic logic [127:0] pick(input int ch, input int n, input bit want_tick);
    logic [127:0] r = '0;
    for (int k = 0; k < n; k++) r[k] = want_tick ? st[k][ch] : so[k][ch];
    return r;
  endfunction

  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      so[k] = outclk;
      st[k] = tick;
      step();
    end
  endtask

  // Steps until locked (bounded); quiet drops if anything leaks out while unlocked.
  task automatic relock(output int lat, output bit quiet);
    lat = 0;
    quiet = 1'b1;
    while (!locked && lat < 100) begin
      if (outclk != '0 || tick != '0 || cfg_ready) quiet = 1'b0;
      step();
      lat++;
    end
  endtask

  task automatic send(input logic [3:0] ch, input int d, input int p);
    cfg_chan  = ch;
    cfg_div   = 16'(d);
    cfg_phase = 16'(p);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    bit quiet;
    rst = 1'b0;
    repeat (3) step();
    total++;
    if ({outclk, tick, locked, cfg_ready, cfg_err} !== '0)
      $display("FAIL reset_outputs got %b want 0", {outclk, tick, locked, cfg_ready, cfg_err});
    else passed++;
    rst = 1'b1;
    relock(lat, quiet);
    total++;
    if (lat !== 16) $display("FAIL powerup_lock_latency got %0d want 16", lat);
    else passed++;
    total++;
    if (quiet !== 1'b1) $display("FAIL powerup_quiet got %b want 1", quiet);
    else passed++;
    capture(84);
    for (int ch = 0; ch < N; ch++) begin
      total++;
      if (pick(ch, 84, 0) !== model(42, 0, 0, 84, 0))
        $display("FAIL powerup_outclk ch%0d got %h want %h", ch, pick(ch, 84, 0),
                 model(42, 0, 0, 84, 0));
      else passed++;
      total++;
      if (pick(ch, 84, 1) !== model(42, 0, 0, 84, 1))
        $display("FAIL powerup_tick ch%0d got %h want %h", ch, pick(ch, 84, 1),
                 model(42, 0, 0, 84, 1));
      else passed++;
    end
  endtask

  task automatic test_reconfig();
    int lat;
    bit quiet;
    send(4'd1, 5, 0);
    total++;
    if (locked !== 1'b0 || outclk !== '0)
      $display("FAIL reconfig_unlock got locked=%b outclk=%b want 0/0", locked, outclk);
    else passed++;
    relock(lat, quiet);
    total++;
    if (lat !== 16 || quiet !== 1'b1)
      $display("FAIL reconfig_relock got lat=%0d quiet=%b want 16/1", lat, quiet);
    else passed++;
    capture(84);
    for (int ch = 0; ch < N; ch++) begin
      int d = (ch == 1) ? 5 : 42;
      total++;
      if (pick(ch, 84, 0) !== model(d, 0, 0, 84, 0) || pick(ch, 84, 1) !== model(d, 0, 0, 84, 1))
        $display("FAIL reconfig_chan ch%0d got %h/%h want %h/%h", ch, pick(ch, 84, 0),
                 pick(ch, 84, 1), model(d, 0, 0, 84, 0), model(d, 0, 0, 84, 1));
      else passed++;
    end
  endtask

  task automatic test_div_clamp();
    int lat;
    bit quiet;
    for (int v = 1; v >= 0; v--) begin
      send(4'd0, v, 0);
      relock(lat, quiet);
      capture(12);
      total++;
      if (pick(0, 12, 0) !== model(2, 0, 0, 12, 0) || pick(0, 12, 1) !== model(2, 0, 0, 12, 1))
        $display("FAIL div_clamp_%0d got %h/%h want %h/%h", v, pick(0, 12, 0), pick(0, 12, 1),
                 model(2, 0, 0, 12, 0), model(2, 0, 0, 12, 1));
      else passed++;
    end
    total++;
    if (pick(1, 12, 0) !== model(5, 0, 0, 12, 0))
      $display("FAIL div_clamp_ch1_kept got %h want %h", pick(1, 12, 0), model(5, 0, 0, 12, 0));
    else passed++;
  endtask

  task automatic test_phase();
    int lat;
    bit quiet;
    send(4'd2, 8, 3);
    relock(lat, quiet);
    capture(16);
    total++;
    if (so[0][2] !== 1'b1) $display("FAIL phase_first_high got %b want 1", so[0][2]);
    else passed++;
    total++;
    if (pick(2, 16, 0) !== model(8, 3, 0, 16, 0) || pick(2, 16, 1) !== model(8, 3, 0, 16, 1))
      $display("FAIL phase3 got %h/%h want %h/%h", pick(2, 16, 0), pick(2, 16, 1),
               model(8, 3, 0, 16, 0), model(8, 3, 0, 16, 1));
    else passed++;
    send(4'd2, 8, 9);
    relock(lat, quiet);
    capture(16);
    total++;
    if (pick(2, 16, 0) !== model(8, 0, 0, 16, 0) || pick(2, 16, 1) !== model(8, 0, 0, 16, 1))
      $display("FAIL phase9_clamp got %h/%h want %h/%h", pick(2, 16, 0), pick(2, 16, 1),
               model(8, 0, 0, 16, 0), model(8, 0, 0, 16, 1));
    else passed++;
  endtask

  task automatic test_bad_chan_and_ignore();
    int lat;
    bit quiet;
    int dv [N] = '{2, 5, 8, 42};
    // Entered 16 cycles after the last lock.
    send(4'd7, 3, 0);
    total++;
    if (cfg_err !== 1'b1 || locked !== 1'b1)
      $display("FAIL bad_chan_err got err=%b locked=%b want 1/1", cfg_err, locked);
    else passed++;
    step();
    total++;
    if (cfg_err !== 1'b0) $display("FAIL bad_chan_err_pulse got %b want 0", cfg_err);
    else passed++;
    capture(84);
    for (int ch = 0; ch < N; ch++) begin
      total++;
      if (pick(ch, 84, 0) !== model(dv[ch], 0, 18, 84, 0) ||
          pick(ch, 84, 1) !== model(dv[ch], 0, 18, 84, 1))
        $display("FAIL bad_chan_undisturbed ch%0d got %h want %h", ch, pick(ch, 84, 0),
                 model(dv[ch], 0, 18, 84, 0));
      else passed++;
    end
    send(4'd3, 6, 0);
    cfg_chan  = 4'd3;
    cfg_div   = 16'd3;
    cfg_phase = 16'd0;
    cfg_valid = 1'b1;
    total++;
    if (cfg_ready !== 1'b0) $display("FAIL locking_ready got %b want 0", cfg_ready);
    else passed++;
    repeat (5) step();
    cfg_valid = 1'b0;
    relock(lat, quiet);
    total++;
    if (lat !== 11) $display("FAIL locking_ignore_latency got %0d want 11", lat);
    else passed++;
    capture(24);
    total++;
    if (pick(3, 24, 0) !== model(6, 0, 0, 24, 0) || pick(0, 24, 0) !== model(2, 0, 0, 24, 0))
      $display("FAIL locking_ignore_div got %h want %h", pick(3, 24, 0), model(6, 0, 0, 24, 0));
    else passed++;
  endtask

  task automatic test_reset_midway();
    int lat;
    bit quiet;
    send(4'd1, 5, 0);
    repeat (7) step();
    rst = 1'b0;
    step();
    total++;
    if ({outclk, tick, locked, cfg_ready, cfg_err} !== '0)
      $display("FAIL mid_reset_outputs got %b want 0", {outclk, tick, locked, cfg_ready, cfg_err});
    else passed++;
    rst = 1'b1;
    relock(lat, quiet);
    total++;
    if (lat !== 16 || quiet !== 1'b1)
      $display("FAIL mid_reset_relock got lat=%0d quiet=%b want 16/1", lat, quiet);
    else passed++;
    capture(84);
    for (int ch = 0; ch < N; ch++) begin
      total++;
      if (pick(ch, 84, 0) !== model(42, 0, 0, 84, 0) ||
          pick(ch, 84, 1) !== model(42, 0, 0, 84, 1))
        $display("FAIL mid_reset_default ch%0d got %h want %h", ch, pick(ch, 84, 0),
                 model(42, 0, 0, 84, 0));
      else passed++;
    end
  endtask

  initial begin
    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
    cfg_phase = '0;
    test_reset();
    test_reconfig();
    test_div_clamp();
    test_phase();
    test_bad_chan_and_ignore();
    test_reset_midway();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
